// File: rtl/pulse_log_pkg.sv
// Shared defaults and helpers for the pulse event logger.
package pulse_log_pkg;

  localparam int TS_W_DEF  = 16;
  localparam int DEPTH_DEF = 8;
  localparam int CNT_W_DEF = 8;

  // Occupancy needs one extra bit so that a full FIFO (count == DEPTH) is representable.
  function automatic int level_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with first-word-fall-through head, used as the event log store.
module sync_fifo
  import pulse_log_pkg::*;
#(
  parameter int WIDTH = TS_W_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      push,
  input  logic                      pop,
  input  logic [WIDTH-1:0]          wdata,
  output logic [WIDTH-1:0]          rdata,
  output logic                      full,
  output logic                      empty,
  output logic [level_w(DEPTH)-1:0] count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int LW = level_w(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    count_q, count_d;
  logic             wr_en, rd_en;

  assign full  = (count_q == LW'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;
  assign rdata = mem_q[rd_ptr_q];

  // A push into a full FIFO is legal only when the head leaves on the same edge.
  assign wr_en = push & (~full | (pop & ~empty));
  assign rd_en = pop & ~empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_en) wr_ptr_d = wr_ptr_q + 1'b1;
    if (rd_en) rd_ptr_d = rd_ptr_q + 1'b1;
    case ({wr_en, rd_en})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/pulse_event_logger.sv
// Timestamps qualified event pulses into a log FIFO and counts events lost to overflow.
module pulse_event_logger
  import pulse_log_pkg::*;
#(
  parameter int TS_W  = TS_W_DEF,
  parameter int DEPTH = DEPTH_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic                      clkb,
  input  logic                      rst,
  input  logic                      bit_b,
  input  logic                      en,
  input  logic                      ts_clr,
  output logic                      rd_valid,
  input  logic                      rd_ready,
  output logic [TS_W-1:0]           rd_data,
  output logic [level_w(DEPTH)-1:0] level,
  output logic                      ovf,
  output logic [CNT_W-1:0]          drop_cnt,
  input  logic                      ovf_clr
);

  logic [TS_W-1:0]  ts_q, ts_d;
  logic             ovf_q, ovf_d;
  logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;
  logic             evt, push, pop, drop;
  logic             full, empty;

  assign evt  = bit_b & en;
  assign pop  = rd_ready & ~empty;
  assign push = evt & (~full | pop);
  assign drop = evt & full & ~pop;

  assign rd_valid = ~empty;
  assign ovf      = ovf_q;
  assign drop_cnt = drop_cnt_q;

  always_comb begin
    ts_d       = ts_clr ? '0 : ts_q + 1'b1;
    ovf_d      = ovf_q;
    drop_cnt_d = drop_cnt_q;
    // A drop on the same edge as a clear wins, restarting the count at one.
    if (drop) begin
      ovf_d = 1'b1;
      if (ovf_clr)               drop_cnt_d = CNT_W'(1);
      else if (drop_cnt_q != '1) drop_cnt_d = drop_cnt_q + 1'b1;
    end else if (ovf_clr) begin
      ovf_d      = 1'b0;
      drop_cnt_d = '0;
    end
  end

  always_ff @(posedge clkb or posedge rst) begin
    if (rst) begin
      ts_q       <= '0;
      ovf_q      <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      ts_q       <= ts_d;
      ovf_q      <= ovf_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  sync_fifo #(
    .WIDTH (TS_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clkb),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .wdata (ts_q),
    .rdata (rd_data),
    .full  (full),
    .empty (empty),
    .count (level)
  );

endmodule

// File: tb/tb_pulse_event_logger.sv
// Directed self-checking bench for pulse_event_logger (narrow timestamp and drop counter).
module tb_pulse_event_logger;

  localparam int TS_W  = 4;
  localparam int DEPTH = 8;
  localparam int CNT_W = 2;
  localparam int LW    = 4;

  logic             clkb = 1'b0;
  logic             rst, bit_b, en, ts_clr, rd_ready, ovf_clr;
  logic             rd_valid, ovf;
  logic [TS_W-1:0]  rd_data;
  logic [LW-1:0]    level;
  logic [CNT_W-1:0] drop_cnt;

  int               n_cmp = 0;
  int               n_err = 0;
  logic [TS_W-1:0]  ts_m;
  logic [TS_W-1:0]  stamps [16];
  logic [TS_W-1:0]  s_tmp;

  always #5 clkb = ~clkb;

  pulse_event_logger #(
    .TS_W  (TS_W),
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) dut (
    .clkb     (clkb),
    .rst      (rst),
    .bit_b    (bit_b),
    .en       (en),
    .ts_clr   (ts_clr),
    .rd_valid (rd_valid),
    .rd_ready (rd_ready),
    .rd_data  (rd_data),
    .level    (level),
    .ovf      (ovf),
    .drop_cnt (drop_cnt),
    .ovf_clr  (ovf_clr)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One clock edge; the model counter follows the hardware timestamp.
  task automatic tick();
    @(posedge clkb);
    #1;
    if (!rst) ts_m = ts_clr ? '0 : ts_m + 1'b1;
  endtask

  task automatic pulses(input int n, input int base);
    en    = 1'b1;
    bit_b = 1'b1;
    for (int i = 0; i < n; i++) begin
      stamps[base+i] = ts_m;
      tick();
    end
    bit_b = 1'b0;
  endtask

  task automatic drain(input int n, input int base, input string tag);
    rd_ready = 1'b1;
    for (int i = 0; i < n; i++) begin
      chk($sformatf("%s_valid%0d", tag, i), 32'(rd_valid), 32'd1);
      chk($sformatf("%s_data%0d", tag, i), 32'(rd_data), 32'(stamps[base+i]));
      tick();
    end
    rd_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1; bit_b = 1'b0; en = 1'b0; ts_clr = 1'b0; rd_ready = 1'b0; ovf_clr = 1'b0;
    ts_m = '0;
    repeat (2) @(posedge clkb);
    #1;
    chk("rst_valid", 32'(rd_valid), 32'd0);
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_ovf", 32'(ovf), 32'd0);
    chk("rst_drop", 32'(drop_cnt), 32'd0);
    rst  = 1'b0;
    ts_m = '0;

    // Single event at counter 5, then read it out.
    while (ts_m != 4'd5) tick();
    pulses(1, 0);
    chk("single_valid", 32'(rd_valid), 32'd1);
    chk("single_data", 32'(rd_data), 32'd5);
    chk("single_level", 32'(level), 32'd1);
    rd_ready = 1'b1;
    tick();
    rd_ready = 1'b0;
    chk("single_rd_valid", 32'(rd_valid), 32'd0);
    chk("single_rd_level", 32'(level), 32'd0);

    // Ten events into an eight-deep log with no reader.
    pulses(8, 0);
    chk("fill_level", 32'(level), 32'd8);
    chk("fill_ovf", 32'(ovf), 32'd0);
    chk("fill_drop", 32'(drop_cnt), 32'd0);
    pulses(2, 8);
    chk("ovf_level", 32'(level), 32'd8);
    chk("ovf_flag", 32'(ovf), 32'd1);
    chk("ovf_drop", 32'(drop_cnt), 32'd2);
    drain(8, 0, "order");
    chk("order_level", 32'(level), 32'd0);
    chk("order_valid", 32'(rd_valid), 32'd0);
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    chk("clr_ovf", 32'(ovf), 32'd0);
    chk("clr_drop", 32'(drop_cnt), 32'd0);

    // Full log: event and read on the same edge.
    pulses(8, 0);
    en = 1'b1; bit_b = 1'b1; rd_ready = 1'b1;
    stamps[8] = ts_m;
    tick();
    bit_b = 1'b0; rd_ready = 1'b0;
    chk("rw_level", 32'(level), 32'd8);
    chk("rw_drop", 32'(drop_cnt), 32'd0);
    chk("rw_ovf", 32'(ovf), 32'd0);
    drain(8, 1, "rw");
    chk("rw_empty", 32'(level), 32'd0);

    // Timestamp wrap 15 -> 0.
    while (ts_m != 4'd15) tick();
    pulses(2, 0);
    rd_ready = 1'b1;
    chk("wrap_data15", 32'(rd_data), 32'd15);
    tick();
    chk("wrap_data0", 32'(rd_data), 32'd0);
    tick();
    rd_ready = 1'b0;
    chk("wrap_level", 32'(level), 32'd0);

    // ts_clr at counter 9 with an event on the same edge and the next.
    while (ts_m != 4'd9) tick();
    en = 1'b1; bit_b = 1'b1; ts_clr = 1'b1;
    tick();
    ts_clr = 1'b0;
    tick();
    bit_b = 1'b0;
    chk("tsclr_level", 32'(level), 32'd2);
    chk("tsclr_data9", 32'(rd_data), 32'd9);
    rd_ready = 1'b1;
    tick();
    chk("tsclr_data0", 32'(rd_data), 32'd0);
    tick();
    rd_ready = 1'b0;

    // Drop counter saturation and clear/drop collision.
    pulses(13, 0);
    chk("sat_level", 32'(level), 32'd8);
    chk("sat_drop", 32'(drop_cnt), 32'd3);
    chk("sat_ovf", 32'(ovf), 32'd1);
    ovf_clr = 1'b1; en = 1'b1; bit_b = 1'b1;
    tick();
    ovf_clr = 1'b0; bit_b = 1'b0;
    chk("coll_ovf", 32'(ovf), 32'd1);
    chk("coll_drop", 32'(drop_cnt), 32'd1);
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    chk("clr2_ovf", 32'(ovf), 32'd0);
    chk("clr2_drop", 32'(drop_cnt), 32'd0);
    bit_b = 1'b1;
    tick();
    bit_b = 1'b0;
    chk("pre_rst_drop", 32'(drop_cnt), 32'd1);

    // Asynchronous reset with five entries stored.
    rd_ready = 1'b1;
    repeat (3) tick();
    rd_ready = 1'b0;
    chk("pre_rst_level", 32'(level), 32'd5);
    chk("pre_rst_data", 32'(rd_data), 32'(stamps[3]));
    #2;
    rst = 1'b1;
    #1;
    chk("arst_valid", 32'(rd_valid), 32'd0);
    chk("arst_level", 32'(level), 32'd0);
    chk("arst_ovf", 32'(ovf), 32'd0);
    chk("arst_drop", 32'(drop_cnt), 32'd0);
    tick();
    rst  = 1'b0;
    ts_m = '0;

    // First edge after reset accepts an event.
    en = 1'b1; bit_b = 1'b1;
    tick();
    bit_b = 1'b0;
    chk("first_valid", 32'(rd_valid), 32'd1);
    chk("first_data", 32'(rd_data), 32'd0);
    chk("first_level", 32'(level), 32'd1);
    rd_ready = 1'b1;
    tick();
    chk("first_rd_level", 32'(level), 32'd0);

    // Empty log: event with rd_ready high is written, not read.
    bit_b = 1'b1;
    s_tmp = ts_m;
    tick();
    bit_b = 1'b0;
    chk("empty_rw_level", 32'(level), 32'd1);
    chk("empty_rw_valid", 32'(rd_valid), 32'd1);
    chk("empty_rw_data", 32'(rd_data), 32'(s_tmp));
    tick();
    rd_ready = 1'b0;
    chk("empty_rw_drain", 32'(level), 32'd0);

    // Disabled logging ignores pulses, both empty and full.
    en = 1'b0; bit_b = 1'b1;
    repeat (10) tick();
    bit_b = 1'b0;
    chk("dis_level", 32'(level), 32'd0);
    chk("dis_ovf", 32'(ovf), 32'd0);
    chk("dis_drop", 32'(drop_cnt), 32'd0);
    pulses(8, 0);
    en = 1'b0; bit_b = 1'b1;
    repeat (3) tick();
    bit_b = 1'b0;
    chk("dis_full_level", 32'(level), 32'd8);
    chk("dis_full_ovf", 32'(ovf), 32'd0);
    chk("dis_full_drop", 32'(drop_cnt), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
